// File: rtl/axil_pkg.sv
// ============================================================================
// Module : axil_pkg
// Brief  : Shared AXI-Lite response codes and master-index type.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package axil_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    // Interconnect-wide master count shared by the arbiter and the router.
    localparam int unsigned AXIL_NUM_MASTERS = 4;
    localparam int unsigned AXIL_MST_IDX_W   =
        (AXIL_NUM_MASTERS > 1) ? $clog2(AXIL_NUM_MASTERS) : 1;

    typedef logic [AXIL_MST_IDX_W-1:0] mst_idx_t;

endpackage : axil_pkg

`default_nettype wire

// File: rtl/owner_fifo.sv
// ============================================================================
// Module : owner_fifo
// Brief  : Show-ahead synchronous FIFO of master indices with occupancy count.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module owner_fifo
    import axil_pkg::*;
#(
    parameter int WIDTH = 2,
    parameter int DEPTH = 4,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] head_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [CNT_W-1:0] count_o
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == FULL_CNT);
    assign count_o = count_q;
    assign head_o  = mem_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_i) begin
            wr_ptr_d = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + 1'b1;
        end
        if (pop_i) begin
            rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + 1'b1;
        end
        case ({push_i, pop_i})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: entries are only read while count is non-zero.
    always_ff @(posedge clk) begin
        if (push_i) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

endmodule : owner_fifo

`default_nettype wire

// File: rtl/axil_resp_router.sv
// ============================================================================
// Module : axil_resp_router
// Brief  : Steers B/R responses back to the issuing master via an owner FIFO.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module axil_resp_router
    import axil_pkg::*;
#(
    parameter int N         = 4,
    parameter int PAYLOAD_W = 34,
    parameter int DEPTH     = 4,
    localparam int ID_W     = (N > 1) ? $clog2(N) : 1,
    localparam int CNT_W    = $clog2(DEPTH + 1)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 issue_valid,
    input  logic [N-1:0]         issue_grant,
    output logic                 issue_ready,
    input  logic                 s_valid,
    output logic                 s_ready,
    input  logic [PAYLOAD_W-1:0] s_payload,
    output logic [N-1:0]         m_valid,
    input  logic [N-1:0]         m_ready,
    output logic [PAYLOAD_W-1:0] m_payload,
    output logic [CNT_W-1:0]     outstanding,
    output logic                 orphan_err,
    output logic                 grant_err
);

    logic [ID_W-1:0] grant_idx;
    logic [ID_W-1:0] head_idx;
    logic            fifo_full;
    logic            fifo_empty;
    logic            push;
    logic            pop;
    logic            orphan_err_q, orphan_err_d;
    logic            grant_err_q,  grant_err_d;

    // Lowest set grant bit wins; scanning downward leaves it as the final write.
    always_comb begin
        grant_idx = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (issue_grant[i]) begin
                grant_idx = ID_W'(i);
            end
        end
    end

    assign issue_ready = !fifo_full;
    assign push        = issue_valid && !fifo_full && (|issue_grant);
    assign pop         = s_valid && s_ready;

    owner_fifo #(
        .WIDTH (ID_W),
        .DEPTH (DEPTH)
    ) u_owner_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .push_i      (push),
        .push_data_i (grant_idx),
        .pop_i       (pop),
        .head_o      (head_idx),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty),
        .count_o     (outstanding)
    );

    always_comb begin
        m_valid = '0;
        s_ready = 1'b0;
        if (!fifo_empty) begin
            m_valid[head_idx] = s_valid;
            s_ready           = m_ready[head_idx];
        end
    end

    assign m_payload = s_payload;

    assign orphan_err_d = orphan_err_q || (s_valid && fifo_empty);
    assign grant_err_d  = grant_err_q  || (issue_valid && !(|issue_grant));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            orphan_err_q <= 1'b0;
            grant_err_q  <= 1'b0;
        end else begin
            orphan_err_q <= orphan_err_d;
            grant_err_q  <= grant_err_d;
        end
    end

    assign orphan_err = orphan_err_q;
    assign grant_err  = grant_err_q;

endmodule : axil_resp_router

`default_nettype wire

// File: doc/axil_resp_router.md
# axil_resp_router

Return-path router for the AXI-Lite interconnect: steers slave responses (B or R channel) back to the master that issued the matching request. On every accepted address handshake it records the granted master's index in an in-order owner FIFO. Each response handshake pops the oldest owner and delivers the payload to that master. One instance serves the write-response path and one serves the read-data path, behind the N-way round-robin request arbiter.

## Interface
- N, default 4: number of masters.
- PAYLOAD_W, default 34: response payload width (34 = 32 data + 2 resp for R; set to 2 for B).
- DEPTH, default 4: maximum outstanding transactions; must be ≥1.
- ID_W (localparam): $clog2(N) if N>1, else 1.
- CNT_W (localparam): $clog2(DEPTH+1).

Ports:
- clk  in  1  clock. One clock; reset is synchronous and active-low.
- rst_n  in  1  synchronous active-low reset, sampled on posedge clk.
- issue_valid  in  1  address handshake (AW or AR) completed this cycle.
- issue_grant  in  N  one-hot grant vector of the winning master.
- issue_ready  out  1  owner FIFO can accept an entry (gates arbiter handshake).
- s_valid  in  1  slave response valid.
- s_ready  out  1  slave response accepted.
- s_payload  in  PAYLOAD_W  slave response payload.
- m_valid  out  N  per-master response valid, at most one bit set.
- m_ready  in  N  per-master response ready.
- m_payload  out  PAYLOAD_W  broadcast payload, equal to s_payload.
- outstanding  out  CNT_W  current FIFO occupancy.
- orphan_err  out  1  sticky flag: response arrived with no owner.
- grant_err  out  1  sticky flag: issue_valid with all-zero issue_grant.

## Operation
- Push: when issue_valid && issue_ready && |issue_grant, the FIFO writes the index of the lowest set bit of issue_grant.
- If issue_grant has several bits set, the lowest index is used and no error is raised.
- If issue_valid is high and issue_grant is all zero: no push, and grant_err is set.
- issue_ready = !full. A pop in the same cycle does not free a slot for a same-cycle push; this keeps the path registered-only.
- Head owner h = FIFO head entry, valid only when not empty.
- When not empty: m_valid[h] = s_valid, all other m_valid bits are 0, and s_ready = m_ready[h].
- When empty: m_valid = 0 and s_ready = 0.
- Pop on s_valid && s_ready; the head advances next cycle.
- Push and pop in the same cycle (not full, not empty): occupancy is unchanged and both take effect.
- orphan_err is set on any cycle with s_valid && empty. The response stays stalled, because s_ready = 0.
- Both error flags stay set until reset.
- Read and write pointers wrap modulo DEPTH. Occupancy is tracked by a counter (0..DEPTH); empty = (count==0), full = (count==DEPTH).
- m_payload passes s_payload through combinationally; no storage of the payload.

## Timing
- Zero-cycle response path: s_valid→m_valid and m_ready→s_ready are combinational.
- Push to head visible: an entry pushed at edge k is routable from cycle k+1. A response can therefore be delivered the cycle after its issue.
- outstanding updates one cycle after a push or pop.
- Reset values (rst_n low at an edge): FIFO empty, outstanding=0, issue_ready=1, s_ready=0, m_valid=0, orphan_err=0, grant_err=0.
- Reset mid-operation discards all outstanding owners. Upstream reset is shared, so there are no stale responses.
- Response handshake rules: once m_valid[h] rises, h is stable until the pop, because the head changes only on a pop. Per AXI, s_valid and s_payload are held by the slave.

## Structure
- Package axil_pkg holds: resp codes (RESP_OKAY=2'b00, RESP_EXOKAY=2'b01, RESP_SLVERR=2'b10, RESP_DECERR=2'b11), and the typedef for the master index width used by both the arbiter and the router.
- Sub-module owner_fifo: synchronous FIFO, WIDTH=ID_W, DEPTH param. Provides push/pop/full/empty/count and a head data output (show-ahead).
- Top level contains the one-hot→index priority encoder, the response demux, and the error flags.

## Test plan
- Reset, then idle: issue_ready=1, s_ready=0, m_valid=0000, outstanding=0, both error flags 0.
- Issue grants 0100 then 0001; respond with payload 0x1_DEADBEEF then 0x0_CAFEF00D, m_ready=1111.
  - Required: m_valid=0100 carrying 0x1_DEADBEEF first, then 0001 carrying 0x0_CAFEF00D.
  - outstanding goes 1,2,1,0.
- Fill to DEPTH=4 with grants 1000,0010,0001,0100: issue_ready=0 at outstanding=4.
  - A 5th issue_valid is not pushed.
  - After one pop, issue_ready=1 and routing order is 3,1,0,2.
- Backpressure: outstanding=1 with owner 2, s_valid=1, m_ready=1011.
  - Required: s_ready=0 while m_valid=0100 is held.
  - Raising m_ready[2] gives s_ready=1, a pop, and outstanding=0.
- Simultaneous push/pop at outstanding=2: issue grant 0010 plus a response handshake in the same cycle.
  - Required: outstanding stays 2 and the new owner 1 is queued last.
- Error and wrap cases:
  - s_valid with FIFO empty: orphan_err=1, s_ready=0.
  - issue_valid with grant 0000: grant_err=1 and outstanding unchanged.
  - Reset clears both flags.
  - 10 consecutive issue/response pairs exercise pointer wrap with correct owners.
